// File: rtl/mem_ctrl_if.sv
// Bundle of the fetch port, data port and byte-wide RAM port served by mem_ctrl.
// The master side is the core plus the RAM; the slave side is the controller.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic [31:0]           if_data;
  logic                  if_done;

  logic                  mem_req;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [2:0]            mem_len;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_done;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_wr;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;

  logic                  busy;

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_wr, mem_addr, mem_len, mem_wdata, ram_din,
    input  if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout, busy
  );

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_wr, mem_addr, mem_len, mem_wdata, ram_din,
    output if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout, busy
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetches and data loads/stores onto a byte-wide RAM,
// one byte per cycle, little-endian, with fetch flush and synchronous reset.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IF_READ   = 2'd1,
    MEM_READ  = 2'd2,
    MEM_WRITE = 2'd3
  } state_t;

  state_t                state_q;
  logic [2:0]            cnt_q;
  logic [2:0]            len_q;
  logic [23:0]           wdata_q;
  logic [31:0]           rbuf_q;
  logic [31:0]           rbuf_d;
  logic [2:0]            len_legal;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  ram_wr_q;
  logic [7:0]            ram_dout_q;
  logic [31:0]           if_data_q;
  logic [31:0]           mem_rdata_q;
  logic                  if_done_q;
  logic                  mem_done_q;

  always_comb begin
    len_legal = (bus.mem_len == 3'd1 || bus.mem_len == 3'd2) ? bus.mem_len : 3'd4;
  end

  // ram_din belongs to the address of the previous cycle, so byte cnt-1 lands now.
  always_comb begin
    rbuf_d   = rbuf_q;
    byte_idx = cnt_q[1:0] - 2'd1;
    if (cnt_q != 3'd0) rbuf_d[{byte_idx, 3'b000} +: 8] = bus.ram_din;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q    <= 3'd0;
          rbuf_q   <= '0;
          ram_wr_q <= 1'b0;
          // A requester whose done is showing is skipped so its held req is not re-granted.
          if (bus.mem_req && !mem_done_q) begin
            ram_addr_q <= bus.mem_addr;
            len_q      <= len_legal;
            wdata_q    <= bus.mem_wdata[31:8];
            if (bus.mem_wr) begin
              state_q    <= MEM_WRITE;
              ram_wr_q   <= 1'b1;
              ram_dout_q <= bus.mem_wdata[7:0];
            end else begin
              state_q <= MEM_READ;
            end
          end else if (bus.if_req && !if_done_q) begin
            ram_addr_q <= bus.if_addr;
            len_q      <= 3'd4;
            state_q    <= IF_READ;
          end
        end

        IF_READ, MEM_READ: begin
          rbuf_q <= rbuf_d;
          cnt_q  <= cnt_q + 3'd1;
          if (cnt_q + 3'd1 < len_q) ram_addr_q <= ram_addr_q + ADDR_WIDTH'(1);
          if (state_q == IF_READ && bus.if_flush) begin
            state_q <= IDLE;
          end else if (cnt_q == len_q) begin
            state_q <= IDLE;
            if (state_q == IF_READ) begin
              if_done_q <= 1'b1;
              if_data_q <= rbuf_d;
            end else begin
              mem_done_q  <= 1'b1;
              mem_rdata_q <= rbuf_d;
            end
          end
        end

        MEM_WRITE: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q + 3'd1 == len_q) begin
            state_q    <= IDLE;
            ram_wr_q   <= 1'b0;
            mem_done_q <= 1'b1;
          end else begin
            ram_addr_q <= ram_addr_q + ADDR_WIDTH'(1);
            ram_dout_q <= wdata_q[7:0];
            wdata_q    <= {8'd0, wdata_q[23:8]};
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_data   = if_data_q;
  assign bus.if_done   = if_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_WIDTH, default 32, width of all byte addresses.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: if_req  input  1  instruction fetch request, held until if_done.
REQ-005 SHALL have port: if_addr  input  ADDR_WIDTH  fetch byte address.
REQ-006 SHALL have port: if_flush  input  1  abort an in-flight fetch (redirect).
REQ-007 SHALL have port: if_data  output  32  fetched instruction word.
REQ-008 SHALL have port: if_done  output  1  one-cycle pulse; if_data is valid in this cycle.
REQ-009 SHALL have port: mem_req  input  1  data access request, held until mem_done.
REQ-010 SHALL have port: mem_wr  input  1  1 = store, 0 = load.
REQ-011 SHALL have port: mem_addr  input  ADDR_WIDTH  data byte address.
REQ-012 SHALL have port: mem_len  input  3  byte count; legal values 1, 2 and 4 only.
REQ-013 SHALL have port: mem_wdata  input  32  store data; byte k is bits [8k+7:8k].
REQ-014 SHALL have port: mem_rdata  output  32  load data, zero-filled above mem_len bytes.
REQ-015 SHALL have port: mem_done  output  1  one-cycle pulse; the load or store is complete.
REQ-016 SHALL have port: ram_addr  output  ADDR_WIDTH  byte address to RAM.
REQ-017 SHALL have port: ram_wr  output  1  1 = write ram_dout at ram_addr this cycle.
REQ-018 SHALL have port: ram_dout  output  8  write byte.
REQ-019 SHALL have port: ram_din  input  8  read byte for the address presented in the previous cycle.
REQ-020 SHALL have port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-021 SHALL implement four states: IDLE, IF_READ, MEM_READ, MEM_WRITE.
REQ-022 SHALL grant in IDLE only. mem_req has priority over if_req, because MEM holds the older instruction.
REQ-023 SHALL latch the address, length, write data and op at grant. Fetch length is fixed at 4.
REQ-024 SHALL NOT preempt a transaction once granted.
REQ-025 SHALL ignore a requester's req in the cycle its own done is high, so a held req is not re-granted.
REQ-026 Byte order SHALL be little-endian. Byte k SHALL be at base+k, for k counting from 0 to len-1.
REQ-027 Read states SHALL behave as follows:
- cycle with cnt=c (c<len): ram_addr=base+c, ram_wr=0.
- if c>=1: capture ram_din into byte c-1.
- cycle with cnt=len: capture the last byte only.
- then pulse done, return to IDLE.
REQ-028 Read latency: req first high in IDLE at cycle T implies done high at cycle T+len+2.
REQ-029 Write states: at cnt=c, SHALL drive ram_addr=base+c, ram_wr=1, ram_dout=byte c.
REQ-030 Write latency: done high at T+len+1. ram_wr SHALL be 0 outside the write cycles.
REQ-031 done, if_data and mem_rdata SHALL be registered outputs.
REQ-032 Data outputs SHALL hold their value until the next done of the same port.
REQ-033 if_flush high in any IF_READ cycle SHALL abort the fetch:
- state becomes IDLE at the next edge;
- no if_done is produced.
REQ-034 if_flush SHALL have no effect in IDLE or in the MEM states.
REQ-035 if_flush SHALL take precedence over a same-cycle completion of IF_READ.
REQ-036 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-037 In IDLE, ram_wr SHALL be 0 and ram_addr SHALL hold its last value.
REQ-038 An illegal mem_len SHALL be treated as 4.

Reset
REQ-039 rst high at an edge SHALL set all of the following to 0:
- state=IDLE, cnt;
- if_done, mem_done, ram_wr, busy;
- if_data, mem_rdata, ram_addr, ram_dout.
REQ-040 Reset mid-transaction SHALL abort it: no done pulse, and ram_wr=0 from the next cycle.
REQ-041 Requests held through reset SHALL be granted, per priority, in the first IDLE cycle after rst falls.

Verification
REQ-042 Fetch scenario:
- stimulus: if_req, if_addr=0x100, RAM bytes 13,05,00,00.
- response: ram_addr steps 0x100 to 0x103; if_done at T+6; if_data=0x00000513.
REQ-043 Store scenario:
- stimulus: mem_req, mem_wr=1, mem_len=2, mem_addr=0x2000, mem_wdata=0xAABBCCDD.
- response: writes DD@0x2000, then CC@0x2001; mem_done at T+3.
REQ-044 Simultaneous requests scenario:
- stimulus: if_req and mem_req both high, load mem_len=1 from 0x40 (byte 0x80).
- response: load first, mem_rdata=0x00000080 at T+3; fetch granted at T+4.
REQ-045 Flush scenario:
- stimulus: if_flush in the 2nd IF_READ cycle.
- response: IDLE the next cycle, no if_done; a new if_addr is granted afterwards with correct data.
REQ-046 Reset scenario:
- stimulus: rst during a 4-byte MEM_WRITE at cnt=2.
- response: only bytes 0 and 1 written; no mem_done; all outputs 0.
REQ-047 Wrap-around scenario:
- stimulus: 4-byte load at 0xFFFFFFFE.
- response: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
